// File: rtl/i2c_slave_frontend.sv
// i2c_slave_frontend: oversampled I2C slave that turns bus transfers into
// single-cycle memory write/read strobes with a persistent 16-bit pointer.
module i2c_slave_frontend #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2,
  parameter int         RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);
  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV_ADDR, ST_DEV_ACK, ST_ADDR_HI, ST_ACK_HI, ST_ADDR_LO, ST_ACK_LO,
    ST_WR_DATA, ST_WR_ACK, ST_RD_FETCH, ST_RD_SHIFT, ST_RD_ACK, ST_WAIT_STOP
  } state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] scl_s, sda_s;
  logic scl, sda, scl_d, sda_d, scl_rise, scl_fall, start, stop;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sh, sh_n, lat, lat_n, mem_wdata_n;
  logic [15:0] mem_addr_n;
  logic rw, rw_n, sda_oe_n, mem_we_n, mem_re_n, busy_n;
  assign scl = scl_s[SYNC_STAGES-1];
  assign sda = sda_s[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start = scl & scl_d & sda_d & ~sda;
  assign stop = scl & scl_d & ~sda_d & sda;
  // Synchronisers and delayed copies idle high, matching a released bus
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      scl_s <= '1;
      sda_s <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_s <= {scl_s[SYNC_STAGES-2:0], scl_in};
      sda_s <= {sda_s[SYNC_STAGES-2:0], sda_in};
      scl_d <= scl;
      sda_d <= sda;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sh        <= '0;
      lat       <= '0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh        <= sh_n;
      lat       <= lat_n;
      rw        <= rw_n;
      sda_oe    <= sda_oe_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_we    <= mem_we_n;
      mem_re    <= mem_re_n;
      busy      <= busy_n;
    end
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sh_n        = sh;
    lat_n       = lat;
    rw_n        = rw;
    sda_oe_n    = sda_oe;
    mem_addr_n  = mem_we ? mem_addr + 16'd1 : mem_addr;
    mem_wdata_n = mem_wdata;
    mem_we_n    = 1'b0;
    mem_re_n    = 1'b0;
    busy_n      = busy;
    case (state)
      ST_DEV_ADDR, ST_ADDR_HI, ST_ADDR_LO, ST_WR_DATA: begin
        if (scl_rise) begin
          sh_n  = {sh[6:0], sda};
          cnt_n = cnt + 4'd1;
        end
        if (scl_fall && cnt == 4'd8) begin
          cnt_n    = '0;
          sda_oe_n = 1'b1;
          case (state)
            ST_DEV_ADDR:
              if (sh[7:1] == DEV_ADDR) begin
                busy_n  = 1'b1;
                rw_n    = sh[0];
                state_n = ST_DEV_ACK;
              end else begin
                sda_oe_n = 1'b0;
                state_n  = ST_WAIT_STOP;
              end
            ST_ADDR_HI: begin
              mem_addr_n[15:8] = sh;
              state_n          = ST_ACK_HI;
            end
            ST_ADDR_LO: begin
              mem_addr_n[7:0] = sh;
              state_n         = ST_ACK_LO;
            end
            default: begin
              mem_wdata_n = sh;
              mem_we_n    = 1'b1;
              state_n     = ST_WR_ACK;
            end
          endcase
        end
      end
      ST_DEV_ACK, ST_ACK_HI, ST_ACK_LO, ST_WR_ACK:
        if (scl_fall) begin
          sda_oe_n = 1'b0;
          cnt_n    = '0;
          lat_n    = '0;
          mem_re_n = state == ST_DEV_ACK && rw;
          state_n  = state == ST_DEV_ACK ? (rw ? ST_RD_FETCH : ST_ADDR_HI) :
                     state == ST_ACK_HI  ? ST_ADDR_LO : ST_WR_DATA;
        end
      ST_RD_FETCH: begin
        lat_n = lat + 8'd1;
        if (lat == 8'(RD_LATENCY)) begin
          sh_n       = mem_rdata;
          sda_oe_n   = ~mem_rdata[7];
          mem_addr_n = mem_addr + 16'd1;
          cnt_n      = '0;
          state_n    = ST_RD_SHIFT;
        end
      end
      ST_RD_SHIFT:
        if (scl_fall) begin
          cnt_n    = cnt + 4'd1;
          sh_n     = {sh[6:0], 1'b0};
          sda_oe_n = cnt == 4'd7 ? 1'b0 : ~sh[6];
          state_n  = cnt == 4'd7 ? ST_RD_ACK : ST_RD_SHIFT;
          if (cnt == 4'd7) cnt_n = '0;
        end
      ST_RD_ACK: begin
        // cnt records that the master acknowledged on the rising edge
        if (scl_rise) begin
          if (sda) state_n = ST_WAIT_STOP;
          else cnt_n = 4'd1;
        end
        if (scl_fall && cnt == 4'd1) begin
          cnt_n    = '0;
          lat_n    = '0;
          mem_re_n = 1'b1;
          state_n  = ST_RD_FETCH;
        end
      end
      default: ;
    endcase
    if (start) begin
      state_n  = ST_DEV_ADDR;
      cnt_n    = '0;
      sda_oe_n = 1'b0;
    end else if (stop) begin
      state_n  = ST_IDLE;
      busy_n   = 1'b0;
      sda_oe_n = 1'b0;
    end
  end
endmodule

// File: tb/tb_i2c_slave_frontend.sv
// tb_i2c_slave_frontend: directed I2C master with a latency-1 memory model
// and a strobe log, checking acks, read bytes, strobes and pointer.
module tb_i2c_slave_frontend;
  localparam int Q = 5;
  localparam int H = 10;
  logic clk = 1'b0, reset = 1'b0, scl = 1'b1, sda_m = 1'b1;
  logic [7:0] mem_rdata = 8'h00;
  logic sda_oe, mem_we, mem_re, busy, sda_bus;
  logic [15:0] mem_addr;
  logic [7:0] mem_wdata;
  int n_chk = 0, n_fail = 0;
  int we_cnt = 0, re_cnt = 0, both_cnt = 0;
  logic [15:0] we_addr [16];
  logic [7:0]  we_data [16];
  logic [15:0] re_addr [16];
  logic [7:0]  rd_tbl [4] = '{8'h5A, 8'hC3, 8'hFF, 8'h00};
  assign sda_bus = sda_m & ~sda_oe;
  always #5 clk = ~clk;
  i2c_slave_frontend #(.DEV_ADDR(7'h50), .SYNC_STAGES(2), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );
  always @(posedge clk) begin
    if (mem_we) begin
      we_addr[we_cnt % 16] <= mem_addr;
      we_data[we_cnt % 16] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (mem_re) begin
      re_addr[re_cnt % 16] <= mem_addr;
      mem_rdata <= rd_tbl[re_cnt % 4];
      re_cnt <= re_cnt + 1;
    end
    if (mem_we && mem_re) both_cnt <= both_cnt + 1;
  end
  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic bit_out(input logic b);
    sda_m = b; wclk(Q); scl = 1'b1; wclk(H); scl = 1'b0; wclk(Q);
  endtask
  task automatic start_c;
    sda_m = 1'b1; wclk(Q); scl = 1'b1; wclk(Q); sda_m = 1'b0; wclk(Q); scl = 1'b0; wclk(Q);
  endtask
  task automatic stop_c;
    sda_m = 1'b0; wclk(Q); scl = 1'b1; wclk(Q); sda_m = 1'b1; wclk(H);
  endtask
  task automatic byte_out(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    sda_m = 1'b1; wclk(Q); ack = ~sda_bus;
    scl = 1'b1; wclk(H); scl = 1'b0; wclk(Q);
  endtask
  task automatic byte_in(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wclk(Q); b[i] = sda_bus;
      scl = 1'b1; wclk(H); scl = 1'b0; wclk(Q);
    end
    bit_out(nack);
  endtask
  initial begin
    logic a, a2, a3, a4, a5;
    logic [7:0] rb;
    wclk(3);
    chk("rst sda_oe", sda_oe, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_re", mem_re, 0);
    chk("rst busy", busy, 0);
    reset = 1'b1; wclk(5);
    // Two-byte write at 0x1234
    start_c; byte_out(8'hA0, a);
    chk("t1 dev ack", a, 1);
    chk("t1 busy", busy, 1);
    byte_out(8'h12, a); byte_out(8'h34, a2); byte_out(8'hAB, a3); byte_out(8'hCD, a4);
    chk("t1 byte acks", {a, a2, a3, a4}, 4'hF);
    stop_c;
    chk("t1 busy after stop", busy, 0);
    chk("t1 we count", we_cnt, 2);
    chk("t1 w0", {we_addr[0], we_data[0]}, 24'h1234AB);
    chk("t1 w1", {we_addr[1], we_data[1]}, 24'h1235CD);
    chk("t1 pointer", mem_addr, 16'h1236);
    // Set pointer 0x0010, repeated START, read three bytes
    start_c; byte_out(8'hA0, a); byte_out(8'h00, a2); byte_out(8'h10, a3);
    start_c; byte_out(8'hA1, a4);
    chk("t2 acks", {a, a2, a3, a4}, 4'hF);
    byte_in(1'b0, rb); chk("t2 rd0", rb, 8'h5A);
    byte_in(1'b0, rb); chk("t2 rd1", rb, 8'hC3);
    byte_in(1'b1, rb); chk("t2 rd2", rb, 8'hFF);
    chk("t2 released after nack", sda_oe, 0);
    chk("t2 busy before stop", busy, 1);
    stop_c;
    chk("t2 re count", re_cnt, 3);
    chk("t2 re addrs", {re_addr[0], re_addr[1], re_addr[2]}, 48'h001000110012);
    chk("t2 pointer", mem_addr, 16'h0013);
    chk("t2 no writes", we_cnt, 2);
    // Wrong device address is ignored
    start_c; byte_out(8'hA2, a);
    chk("t3 no dev ack", a, 0);
    chk("t3 busy", busy, 0);
    byte_out(8'h55, a);
    chk("t3 no data ack", a, 0);
    stop_c;
    chk("t3 strobes", {we_cnt[7:0], re_cnt[7:0]}, 16'h0203);
    // Pointer wrap 0xFFFF -> 0x0000
    start_c; byte_out(8'hA0, a); byte_out(8'hFF, a2); byte_out(8'hFF, a3);
    byte_out(8'h01, a4); byte_out(8'h02, a5);
    chk("t4 acks", {a, a2, a3, a4, a5}, 5'h1F);
    stop_c;
    chk("t4 we count", we_cnt, 4);
    chk("t4 w2", {we_addr[2], we_data[2]}, 24'hFFFF01);
    chk("t4 w3", {we_addr[3], we_data[3]}, 24'h000002);
    chk("t4 pointer", mem_addr, 16'h0001);
    // STOP after a partial data byte
    start_c; byte_out(8'hA0, a); byte_out(8'h00, a2); byte_out(8'h40, a3);
    chk("t5 acks", {a, a2, a3}, 3'h7);
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
    stop_c;
    chk("t5 no write", we_cnt, 4);
    chk("t5 pointer", mem_addr, 16'h0040);
    chk("t5 busy", busy, 0);
    // Async reset while driving read data
    start_c; byte_out(8'hA1, a);
    chk("t6 dev ack", a, 1);
    for (int i = 0; i < 20 && !sda_oe; i++) wclk(1);
    chk("t6 driving low", sda_oe, 1);
    chk("t6 re addr", re_addr[3], 16'h0040);
    #2 reset = 1'b0;
    #1;
    chk("t6 async sda_oe", sda_oe, 0);
    chk("t6 async outs", {mem_addr, mem_wdata, mem_we, mem_re, busy}, 27'h0);
    scl = 1'b1; sda_m = 1'b1; wclk(3);
    reset = 1'b1; wclk(5);
    start_c; byte_out(8'hA0, a); byte_out(8'h00, a2); byte_out(8'h05, a3); byte_out(8'h77, a4);
    chk("t6 post-reset acks", {a, a2, a3, a4}, 4'hF);
    stop_c;
    chk("t6 we count", we_cnt, 5);
    chk("t6 w4", {we_addr[4], we_data[4]}, 24'h000577);
    chk("t6 pointer", mem_addr, 16'h0006);
    chk("we/re exclusive", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
